port_sequence_matcher: RTL and testbench

PORT_SEQUENCE_MATCHER -- requirements
Module: port_sequence_matcher

---
 rtl/port_sequence_matcher.sv | 196 +++++++++++++++++++
 tb/tb_port_sequence_matcher.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_sequence_matcher.sv
// Port sequence matcher: debounces a button/port value and checks the press/release
// sequence against a programmable table of up to DEPTH patterns, with an inter-step
// timeout and a lockout that waits for the port to be released after a rejection.
module port_sequence_matcher #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 3,
    parameter int TIMEOUT     = 50
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         port_input,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [WIDTH-1:0]         prog_data,
    input  logic                     len_we,
    input  logic [$clog2(DEPTH):0]   len_data,
    output logic                     match,
    output logic                     fail,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_RELEASE = 2'd1,
        WAIT_PRESS   = 2'd2,
        LOCKOUT      = 2'd3
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  sample_r;
    logic [CW-1:0]     cnt_r;
    logic [WIDTH-1:0]  deb_r;
    logic [TW-1:0]     timer_r;
    logic [LW-1:0]     seq_len_r;
    logic [WIDTH-1:0]  pattern_r [DEPTH];
    logic [AW-1:0]     step_r;
    logic              match_r;
    logic              fail_r;
    logic              busy_r;

    logic [CW-1:0]     cnt_next_s;
    logic              deb_load_s;
    logic              event_s;
    logic              write_s;
    logic              step_last_s;
    logic              timeout_s;
    logic [LW-1:0]     len_clip_s;

    // Debounce run-length counter (saturating) and the event a debounced change raises.
    always_comb begin
        cnt_next_s = cnt_r;
        if (port_input != sample_r) begin
            cnt_next_s = CW'(1);
        end else if (cnt_r != CW'(HOLD_CYCLES)) begin
            cnt_next_s = cnt_r + CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
        deb_load_s = (cnt_next_s == CW'(HOLD_CYCLES));
        event_s    = deb_load_s && (port_input != deb_r);
    end

    // Helper decodes: table writes, last step of the sequence, timer expiry, length clamp.
    always_comb begin
        write_s     = prog_we || len_we;
        step_last_s = (({1'b0, step_r} + LW'(1)) == seq_len_r);
        timeout_s   = (timer_r == TW'(TIMEOUT - 1));
        if (len_data > LW'(DEPTH)) begin
            len_clip_s = LW'(DEPTH);
        end else begin
            len_clip_s = len_data;
        end
    end

    // Debouncer, pattern table, inter-step timer and sequence FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            sample_r  <= '0;
            cnt_r     <= '0;
            deb_r     <= '0;
            timer_r   <= '0;
            seq_len_r <= '0;
            step_r    <= '0;
            match_r   <= 1'b0;
            fail_r    <= 1'b0;
            busy_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pattern_r[i] <= '0;
            end
        end else begin
            sample_r <= port_input;
            cnt_r    <= cnt_next_s;
            if (deb_load_s) begin
                deb_r <= port_input;
            end
            match_r <= 1'b0;
            fail_r  <= 1'b0;
            if (prog_we) begin
                pattern_r[prog_addr] <= prog_data;
            end
            if (len_we) begin
                seq_len_r <= len_clip_s;
            end
            // A table write always aborts the sequence silently and swallows any event.
            if (write_s) begin
                state_r <= IDLE;
                step_r  <= '0;
                busy_r  <= 1'b0;
                timer_r <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (event_s && (seq_len_r != '0) && (port_input != '0)) begin
                            busy_r <= 1'b1;
                            if (port_input == pattern_r[0]) begin
                                state_r <= WAIT_RELEASE;
                                step_r  <= '0;
                                timer_r <= '0;
                            end else begin
                                fail_r  <= 1'b1;
                                state_r <= LOCKOUT;
                            end
                        end
                    end
                    WAIT_RELEASE: begin
                        if (event_s) begin
                            if (port_input == '0) begin
                                if (step_last_s) begin
                                    match_r <= 1'b1;
                                    state_r <= IDLE;
                                    step_r  <= '0;
                                    busy_r  <= 1'b0;
                                end else begin
                                    step_r  <= step_r + AW'(1);
                                    state_r <= WAIT_PRESS;
                                    timer_r <= '0;
                                end
                            end else begin
                                fail_r  <= 1'b1;
                                state_r <= LOCKOUT;
                            end
                        end else if (timeout_s) begin
                            fail_r  <= 1'b1;
                            state_r <= LOCKOUT;
                        end else begin
                            timer_r <= timer_r + TW'(1);
                        end
                    end
                    WAIT_PRESS: begin
                        if (event_s) begin
                            // Zero denotes release, so a zero pattern slot can never be pressed.
                            if ((port_input == pattern_r[step_r]) && (port_input != '0)) begin
                                state_r <= WAIT_RELEASE;
                                timer_r <= '0;
                            end else begin
                                fail_r  <= 1'b1;
                                state_r <= LOCKOUT;
                            end
                        end else if (timeout_s) begin
                            fail_r  <= 1'b1;
                            state_r <= LOCKOUT;
                        end else begin
                            timer_r <= timer_r + TW'(1);
                        end
                    end
                    LOCKOUT: begin
                        if (deb_r == '0) begin
                            state_r <= IDLE;
                            step_r  <= '0;
                            busy_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        step_r  <= '0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign match = match_r;
    assign fail  = fail_r;
    assign busy  = busy_r;
    assign step  = step_r;

endmodule

// File: tb/tb_port_sequence_matcher.sv
// Testbench for port_sequence_matcher: directed vector table, hand-written corner
// sequences and randomized stimulus, all compared against a behavioural model.
module tb_port_sequence_matcher;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int HOLD  = 3;
    localparam int TMO   = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] port_input;
    logic       prog_we;
    logic [1:0] prog_addr;
    logic [3:0] prog_data;
    logic       len_we;
    logic [2:0] len_data;
    logic       match;
    logic       fail;
    logic       busy;
    logic [1:0] step;

    int errors = 0;
    int checks = 0;

    port_sequence_matcher #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .port_input(port_input),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .len_we(len_we), .len_data(len_data),
        .match(match), .fail(fail), .busy(busy), .step(step)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Modes: 0 idle, 1 holding a correct press, 2 waiting for next press, 3 locked out.
    int         cyc = 0;
    int         m_run = 0;
    logic [3:0] m_last = 4'd0;
    logic [3:0] m_deb = 4'd0;
    logic [3:0] m_pat [4];
    int         m_len = 0;
    int         m_mode = 0;
    int         m_idx = 0;
    int         m_deadline = 0;
    bit         m_match = 1'b0;
    bit         m_fail = 1'b0;

    function automatic void model_edge();
        logic [3:0] pi;
        logic [3:0] deb_before;
        bit         ev;
        pi = port_input;
        cyc++;
        m_match = 1'b0;
        m_fail  = 1'b0;
        if (reset) begin
            m_run = 0; m_last = 4'd0; m_deb = 4'd0; m_len = 0;
            m_mode = 0; m_idx = 0;
            for (int i = 0; i < 4; i++) m_pat[i] = 4'd0;
            return;
        end
        m_run      = (pi == m_last) ? m_run + 1 : 1;
        m_last     = pi;
        deb_before = m_deb;
        ev         = (m_run == HOLD) && (pi != m_deb);
        if (m_run == HOLD) m_deb = pi;
        if (prog_we || len_we) begin
            if (prog_we) m_pat[prog_addr] = prog_data;
            if (len_we) m_len = (int'(len_data) > DEPTH) ? DEPTH : int'(len_data);
            m_mode = 0;
            m_idx  = 0;
        end else begin
            case (m_mode)
                0: if (ev && m_len > 0 && pi != 4'd0) begin
                       if (pi == m_pat[0]) begin m_mode = 1; m_idx = 0; m_deadline = cyc + TMO; end
                       else begin m_fail = 1'b1; m_mode = 3; end
                   end
                1: if (ev) begin
                       if (pi == 4'd0) begin
                           if (m_idx == m_len - 1) begin m_match = 1'b1; m_mode = 0; m_idx = 0; end
                           else begin m_idx++; m_mode = 2; m_deadline = cyc + TMO; end
                       end else begin m_fail = 1'b1; m_mode = 3; end
                   end else if (cyc == m_deadline) begin m_fail = 1'b1; m_mode = 3; end
                2: if (ev) begin
                       if (pi != 4'd0 && pi == m_pat[m_idx]) begin m_mode = 1; m_deadline = cyc + TMO; end
                       else begin m_fail = 1'b1; m_mode = 3; end
                   end else if (cyc == m_deadline) begin m_fail = 1'b1; m_mode = 3; end
                default: if (deb_before == 4'd0) begin m_mode = 0; m_idx = 0; end
            endcase
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [4:0] exp_v;
        logic [4:0] act_v;
        model_edge();
        @(posedge clk);
        #1;
        exp_v = {m_match, m_fail, (m_mode != 0), 2'(m_idx)};
        act_v = {match, fail, busy, step};
        check("model{match,fail,busy,step}", int'(act_v), int'(exp_v));
    endtask

    task automatic hold(input logic [3:0] v, input int n,
                        output int mc, output int fc, output int mat, output int fat);
        mc = 0; fc = 0; mat = 0; fat = 0;
        port_input = v;
        for (int t = 1; t <= n; t++) begin
            tick();
            if (match) begin mc++; if (mat == 0) mat = t; end
            if (fail)  begin fc++; if (fat == 0) fat = t; end
        end
    endtask

    task automatic prog(input logic [1:0] a, input logic [3:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic set_len(input logic [2:0] l);
        len_we = 1'b1; len_data = l;
        tick();
        len_we = 1'b0;
    endtask

    typedef struct {
        logic [3:0] pin;
        int cycles;
        int exp_m;
        int exp_m_at;
        int exp_f;
        int exp_f_at;
        int exp_busy;
        int exp_step;
    } vec_t;

    vec_t tbl[$];

    task automatic run_tbl(input int lo, input int hi);
        int mc, fc, mat, fat;
        for (int i = lo; i <= hi; i++) begin
            hold(tbl[i].pin, tbl[i].cycles, mc, fc, mat, fat);
            check($sformatf("vec%0d match_count", i), mc, tbl[i].exp_m);
            check($sformatf("vec%0d match_cycle", i), mat, tbl[i].exp_m_at);
            check($sformatf("vec%0d fail_count", i), fc, tbl[i].exp_f);
            check($sformatf("vec%0d fail_cycle", i), fat, tbl[i].exp_f_at);
            check($sformatf("vec%0d busy", i), int'(busy), tbl[i].exp_busy);
            check($sformatf("vec%0d step", i), int'(step), tbl[i].exp_step);
        end
    endtask

    initial begin
        int mc, fc, mat, fat, tot_m, tot_f;
        logic [3:0] v;
        int k, n;

        // pin, cycles, matches, match cycle, fails, fail cycle, busy, step
        tbl.push_back('{4'b0010, 10, 0, 0, 0, 0, 1, 0});  // 0: single-step press
        tbl.push_back('{4'b0000, 10, 1, 3, 0, 0, 0, 0});  // 1: release -> match
        tbl.push_back('{4'b0010, 10, 0, 0, 0, 0, 1, 0});  // 2: two-step, first press
        tbl.push_back('{4'b0000, 10, 0, 0, 0, 0, 1, 1});  // 3: first release -> step 1
        tbl.push_back('{4'b0100, 10, 0, 0, 0, 0, 1, 1});  // 4: second press
        tbl.push_back('{4'b0000, 10, 1, 3, 0, 0, 0, 0});  // 5: second release -> match
        tbl.push_back('{4'b1000, 10, 0, 0, 1, 3, 1, 0});  // 6: wrong press -> lockout
        tbl.push_back('{4'b0000, 10, 0, 0, 0, 0, 0, 0});  // 7: release leaves lockout
        tbl.push_back('{4'b0010,  2, 0, 0, 0, 0, 0, 0});  // 8: glitch too short
        tbl.push_back('{4'b0000, 10, 0, 0, 0, 0, 0, 0});  // 9: nothing happened
        tbl.push_back('{4'b0010, 10, 0, 0, 0, 0, 1, 0});  // 10: press
        tbl.push_back('{4'b0000, 60, 0, 0, 1, 53, 0, 0}); // 11: timeout 50 after release

        reset = 1'b1; port_input = 4'd0; prog_we = 1'b0; prog_addr = 2'd0;
        prog_data = 4'd0; len_we = 1'b0; len_data = 3'd0;
        tick();
        tick();
        check("reset match", int'(match), 0);
        check("reset fail", int'(fail), 0);
        check("reset busy", int'(busy), 0);
        check("reset step", int'(step), 0);
        reset = 1'b0;

        // With no length programmed every press is ignored.
        hold(4'b0010, 10, mc, fc, mat, fat);
        check("len0 fail_count", fc, 0);
        check("len0 busy", int'(busy), 0);
        hold(4'b0000, 10, mc, fc, mat, fat);

        prog(2'd0, 4'b0010);
        set_len(3'd1);
        run_tbl(0, 1);
        prog(2'd1, 4'b0100);
        set_len(3'd2);
        run_tbl(2, 11);

        // A pattern write coinciding with the debounced press swallows the event.
        port_input = 4'b0010;
        tick();
        tick();
        prog(2'd3, 4'b0110);
        hold(4'b0010, 7, mc, fc, mat, fat);
        check("write_wins busy", int'(busy), 0);
        check("write_wins fail_count", fc, 0);
        hold(4'b0000, 10, mc, fc, mat, fat);
        check("write_wins release busy", int'(busy), 0);

        // A length write mid-sequence aborts silently.
        hold(4'b0010, 10, mc, fc, mat, fat);
        check("abort pre busy", int'(busy), 1);
        set_len(3'd2);
        check("abort busy", int'(busy), 0);
        hold(4'b0000, 10, mc, fc, mat, fat);
        check("abort fail_count", fc, 0);
        check("abort idle busy", int'(busy), 0);

        // A zero pattern slot can never be matched.
        prog(2'd0, 4'b0000);
        set_len(3'd1);
        hold(4'b0010, 10, mc, fc, mat, fat);
        check("zero_pat fail_count", fc, 1);
        hold(4'b0000, 10, mc, fc, mat, fat);
        check("zero_pat match_count", mc, 0);
        check("zero_pat busy", int'(busy), 0);

        // Oversized length clamps to DEPTH: four steps, one match at the very end.
        prog(2'd0, 4'b0001); prog(2'd1, 4'b0010); prog(2'd2, 4'b0100); prog(2'd3, 4'b1000);
        set_len(3'd7);
        tot_m = 0; tot_f = 0;
        for (int s = 0; s < 4; s++) begin
            v = 4'b0001 << s;
            hold(v, 8, mc, fc, mat, fat); tot_m += mc; tot_f += fc;
            hold(4'b0000, 8, mc, fc, mat, fat); tot_m += mc; tot_f += fc;
            if (s == 2) check("clamp step before last", int'(step), 3);
        end
        check("clamp match_count", tot_m, 1);
        check("clamp fail_count", tot_f, 0);

        // Reset held two cycles while waiting for the second press.
        prog(2'd0, 4'b0010); prog(2'd1, 4'b0100);
        set_len(3'd2);
        hold(4'b0010, 10, mc, fc, mat, fat);
        hold(4'b0000, 10, mc, fc, mat, fat);
        check("pre-reset step", int'(step), 1);
        check("pre-reset busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("midseq reset match", int'(match), 0);
        check("midseq reset fail", int'(fail), 0);
        check("midseq reset busy", int'(busy), 0);
        check("midseq reset step", int'(step), 0);
        tick();
        check("post-reset busy", int'(busy), 0);

        // Randomized traffic against the model.
        prog(2'd0, 4'($urandom_range(1, 15)));
        prog(2'd1, 4'($urandom_range(1, 15)));
        prog(2'd2, 4'($urandom_range(1, 15)));
        prog(2'd3, 4'($urandom_range(1, 15)));
        set_len(3'($urandom_range(1, 4)));
        for (int r = 0; r < 400; r++) begin
            k = $urandom_range(0, 39);
            if (k == 0) begin
                prog(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            end else if (k == 1) begin
                set_len(3'($urandom_range(0, 7)));
            end else if (k == 2) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                case ($urandom_range(0, 4))
                    0, 1:    v = 4'd0;
                    2, 3:    v = m_pat[m_idx];
                    default: v = 4'($urandom_range(0, 15));
                endcase
                n = ($urandom_range(0, 19) == 0) ? 55 : $urandom_range(1, 8);
                hold(v, n, mc, fc, mat, fat);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
